// File: rtl/status_value_queue.sv
// Registered DEPTH x WIDTH status/value queue with head fixed at entry 0.
// Pull compacts by shifting down; push, tail-set and indexed update all resolve against pre-edge state.
module status_value_queue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_value_i,
  input  logic                     pull_i,
  input  logic                     set_i,
  input  logic [WIDTH-1:0]         set_value_i,
  input  logic                     upd_i,
  input  logic [IW-1:0]            upd_idx_i,
  input  logic [WIDTH-1:0]         upd_value_i,
  output logic [DEPTH*WIDTH-1:0]   vector_o,
  output logic [DEPTH-1:0]         valid_o,
  output logic [WIDTH-1:0]         head_o,
  output logic [WIDTH-1:0]         tail_o,
  output logic [CW-1:0]            count_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  logic [WIDTH-1:0] entries_r [DEPTH];
  logic [WIDTH-1:0] entries_s [DEPTH];
  logic [WIDTH-1:0] shift_s   [DEPTH];
  logic [CW-1:0]    count_r, count_s;
  logic [DEPTH-1:0] valid_r, valid_s;
  logic [WIDTH-1:0] tail_r, tail_s;
  logic             empty_r, empty_s;
  logic             full_r, full_s;
  logic             overflow_r, overflow_s;
  logic             underflow_r, underflow_s;

  logic             pull_acc_s, push_acc_s, set_hit_s, upd_hit_s;
  int               cnt_s, cnt_next_s, idx_s, adj_s;
  int               set_tgt_s, upd_tgt_s, push_tgt_s;

  // Next-state computation: accept/ignore decisions, shifted image, targeted writes.
  always_comb begin
    cnt_s       = int'(count_r);
    idx_s       = int'(upd_idx_i);
    pull_acc_s  = pull_i && (cnt_s != 0);
    push_acc_s  = push_i && ((cnt_s < DEPTH) || pull_acc_s);
    set_hit_s   = set_i && (cnt_s != 0) && !((cnt_s == 1) && pull_acc_s);
    upd_hit_s   = upd_i && (idx_s < cnt_s) && !((idx_s == 0) && pull_acc_s);
    adj_s       = pull_acc_s ? 1 : 0;
    // Pre-edge positions move down by one when the head leaves.
    set_tgt_s   = cnt_s - 1 - adj_s;
    upd_tgt_s   = idx_s - adj_s;
    push_tgt_s  = cnt_s - adj_s;
    cnt_next_s  = cnt_s - adj_s + (push_acc_s ? 1 : 0);

    for (int i = 0; i < DEPTH - 1; i++) begin
      shift_s[i] = entries_r[i + 1];
    end
    shift_s[DEPTH-1] = {WIDTH{1'b0}};

    tail_s = {WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      // Update beats set on a shared slot; push never shares a slot with either.
      if (push_acc_s && (i == push_tgt_s)) begin
        entries_s[i] = push_value_i;
      end else if (upd_hit_s && (i == upd_tgt_s)) begin
        entries_s[i] = upd_value_i;
      end else if (set_hit_s && (i == set_tgt_s)) begin
        entries_s[i] = set_value_i;
      end else if (pull_acc_s) begin
        entries_s[i] = shift_s[i];
      end else begin
        entries_s[i] = entries_r[i];
      end
      valid_s[i] = (i < cnt_next_s);
      tail_s     = tail_s | ((i == cnt_next_s - 1) ? entries_s[i] : {WIDTH{1'b0}});
    end

    count_s     = CW'(cnt_next_s);
    empty_s     = (cnt_next_s == 0);
    full_s      = (cnt_next_s == DEPTH);
    overflow_s  = push_i && !push_acc_s;
    underflow_s = pull_i && (cnt_s == 0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= {WIDTH{1'b0}};
      end
      count_r     <= {CW{1'b0}};
      valid_r     <= {DEPTH{1'b0}};
      tail_r      <= {WIDTH{1'b0}};
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= entries_s[i];
      end
      count_r     <= count_s;
      valid_r     <= valid_s;
      tail_r      <= tail_s;
      empty_r     <= empty_s;
      full_r      <= full_s;
      overflow_r  <= overflow_s;
      underflow_r <= underflow_s;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_vec
    assign vector_o[g*WIDTH +: WIDTH] = entries_r[g];
  end

  assign valid_o     = valid_r;
  assign head_o      = entries_r[0];
  assign tail_o      = tail_r;
  assign count_o     = count_r;
  assign empty_o     = empty_r;
  assign full_o      = full_r;
  assign overflow_o  = overflow_r;
  assign underflow_o = underflow_r;

endmodule

// File: tb/tb_status_value_queue.sv
// Scoreboard bench for status_value_queue (WIDTH=4, DEPTH=4): a list-based
// reference model feeds an expectation queue that a separate monitor drains.
module tb_status_value_queue;

  localparam int W = 4;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst_i = 1'b1;
  logic           push_i = 1'b0, pull_i = 1'b0, set_i = 1'b0, upd_i = 1'b0;
  logic [W-1:0]   push_value_i = '0, set_value_i = '0, upd_value_i = '0;
  logic [1:0]     upd_idx_i = '0;
  logic [D*W-1:0] vector_o;
  logic [D-1:0]   valid_o;
  logic [W-1:0]   head_o, tail_o;
  logic [2:0]     count_o;
  logic           empty_o, full_o, overflow_o, underflow_o;

  status_value_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .push_i(push_i), .push_value_i(push_value_i),
    .pull_i(pull_i),
    .set_i(set_i), .set_value_i(set_value_i),
    .upd_i(upd_i), .upd_idx_i(upd_idx_i), .upd_value_i(upd_value_i),
    .vector_o(vector_o), .valid_o(valid_o), .head_o(head_o), .tail_o(tail_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int vec;
    int n;
    int head;
    int tail;
    int ovf;
    int udf;
  } exp_t;

  exp_t exp_q[$];
  int   mq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input int expv);
    checks++;
    if (act !== 32'(expv)) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, expv, $time);
    end
  endtask

  // Drive one cycle of commands and record what the queue must look like after the edge.
  task automatic step(input bit rst, input bit push, input int pv, input bit pull,
                      input bit set, input int sv, input bit upd, input int ui, input int uv);
    exp_t e;
    int   n;
    bit   pull_ok, push_ok;
    @(negedge clk);
    rst_i = rst; push_i = push; push_value_i = 4'(pv); pull_i = pull;
    set_i = set; set_value_i = 4'(sv); upd_i = upd; upd_idx_i = 2'(ui); upd_value_i = 4'(uv);
    e.ovf = 0;
    e.udf = 0;
    if (rst) begin
      mq.delete();
    end else begin
      n = mq.size();
      pull_ok = pull && (n > 0);
      push_ok = push && ((n < D) || pull_ok);
      if (set && n > 0) mq[n-1] = sv;
      if (upd && ui < n) mq[ui] = uv;
      if (pull_ok) void'(mq.pop_front());
      if (push_ok) mq.push_back(pv);
      e.ovf = (push && !push_ok) ? 1 : 0;
      e.udf = (pull && n == 0) ? 1 : 0;
    end
    e.n = mq.size();
    e.vec = 0;
    foreach (mq[i]) e.vec = e.vec | (mq[i] << (4 * i));
    e.head = (e.n > 0) ? mq[0] : 0;
    e.tail = (e.n > 0) ? mq[e.n-1] : 0;
    exp_q.push_back(e);
  endtask

  task automatic idle();              step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic reset_q();           step(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic push(input int v);   step(0, 1, v, 0, 0, 0, 0, 0, 0); endtask

  // Directed spot check right after the edge that follows the last step.
  task automatic spot(input string nm, input int vec, input int cnt);
    @(posedge clk);
    #2;
    chk({nm, "_vector"}, 32'(vector_o), vec);
    chk({nm, "_count"}, 32'(count_o), cnt);
  endtask

  // Monitor: pop one expectation per clock edge and compare every output.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("vector", 32'(vector_o), e.vec);
        chk("count", 32'(count_o), e.n);
        chk("valid", 32'(valid_o), (1 << e.n) - 1);
        chk("head", 32'(head_o), e.head);
        chk("tail", 32'(tail_o), e.tail);
        chk("empty", 32'(empty_o), (e.n == 0) ? 1 : 0);
        chk("full", 32'(full_o), (e.n == D) ? 1 : 0);
        chk("overflow", 32'(overflow_o), e.ovf);
        chk("underflow", 32'(underflow_o), e.udf);
      end
    end
  end

  initial begin
    reset_q();
    spot("reset", 0, 0);
    idle();

    push(1); push(2); push(3); push(4);
    spot("fill", 16'h4321, 4);
    push(5);
    spot("overflow_drop", 16'h4321, 4);
    chk("overflow_pulse", 32'(overflow_o), 1);
    step(0, 1, 5, 1, 0, 0, 0, 0, 0);
    spot("full_push_pull", 16'h5432, 4);
    chk("no_overflow", 32'(overflow_o), 0);

    reset_q(); push(1); push(2); push(3);
    step(0, 0, 0, 1, 1, 9, 0, 0, 0);
    spot("set_pull", 16'h0092, 2);

    reset_q(); push(1); push(2); push(3);
    step(0, 0, 0, 0, 1, 9, 1, 1, 10);
    spot("upd_set", 16'h09A1, 3);
    step(0, 0, 0, 0, 0, 0, 1, 3, 5);
    spot("upd_oob", 16'h09A1, 3);

    reset_q();
    step(0, 1, 7, 1, 0, 0, 0, 0, 0);
    spot("empty_pull_push", 16'h0007, 1);
    chk("underflow_pulse", 32'(underflow_o), 1);
    chk("head_7", 32'(head_o), 7);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    spot("empty_pull", 0, 0);
    chk("underflow_again", 32'(underflow_o), 1);

    push(1); push(2); push(3);
    step(1, 1, 6, 1, 1, 9, 1, 1, 5);
    spot("reset_busy", 0, 0);
    chk("reset_empty", 32'(empty_o), 1);

    for (int c = 0; c < 2000; c++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 6), $urandom_range(0, 15),
           ($urandom_range(0, 9) < 4), ($urandom_range(0, 3) == 0), $urandom_range(0, 15),
           ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 15));
    end

    idle();
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drain", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
